// File: rtl/merge_pkg.sv
// Shared constants for the merge accumulator: default width, saturation limits and counter width.
// Optional saturation is enabled with the MERGE_ACC_SAT_EN macro.
`ifndef DW
`define DW 16
`endif

package merge_pkg;
  localparam int DEF_DW    = `DW;
  localparam int ACC_CNT_W = 5;

  // Signed limits for the default width
  localparam logic [DEF_DW-1:0] SAT_MAX = {1'b0, {(DEF_DW-1){1'b1}}};
  localparam logic [DEF_DW-1:0] SAT_MIN = {1'b1, {(DEF_DW-1){1'b0}}};
endpackage

// File: rtl/merge_fifo.sv
// Result buffer for merge_accumulator: flop-based FIFO with resettable storage,
// no push-to-pop bypass, and push+pop allowed while full.
module merge_fifo #(
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DW-1:0] mem_reg [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic          do_push;
  logic          do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign pop_data = mem_reg[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end
endmodule

// File: rtl/merge_accumulator.sv
// Sums MERGE_NUM signed partial sums per output word and buffers results in merge_fifo.
// Define MERGE_ACC_SAT_EN for saturating additions with a sticky ovf_o flag.
`ifndef DW
`define DW 16
`endif

module merge_accumulator
  import merge_pkg::*;
#(
  parameter int DW         = `DW,
  parameter int MERGE_NUM  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DW-1:0]        data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [DW-1:0]        data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [ACC_CNT_W-1:0] acc_cnt_o,
  output logic                 ovf_o
);
  localparam logic [ACC_CNT_W-1:0] LAST_CNT = ACC_CNT_W'(MERGE_NUM - 1);

  logic [DW-1:0]        acc_reg;
  logic [ACC_CNT_W-1:0] cnt_reg;
  logic [DW-1:0]        base;
  logic [DW-1:0]        sum;
  logic                 last_word;
  logic                 in_fire;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;

  assign last_word = (cnt_reg == LAST_CNT);
  assign pop       = valid_o && ready_i;
  // Stall only the group-closing word, and only if the buffer cannot drain this cycle
  assign ready_o   = !(last_word && fifo_full && !ready_i);
  assign in_fire   = valid_i && ready_o;
  assign push      = in_fire && last_word;
  assign base      = (cnt_reg == '0) ? '0 : acc_reg;
  assign acc_cnt_o = cnt_reg;
  assign valid_o   = !fifo_empty;

`ifdef MERGE_ACC_SAT_EN
  localparam logic [DW-1:0] SAT_HI = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_LO = {1'b1, {(DW-1){1'b0}}};

  logic [DW:0] wide;
  logic        sat_pos;
  logic        sat_neg;
  logic        ovf_reg;

  assign wide    = {base[DW-1], base} + {data_i[DW-1], data_i};
  assign sat_pos = !wide[DW] && wide[DW-1];
  assign sat_neg = wide[DW] && !wide[DW-1];
  assign sum     = sat_pos ? SAT_HI : (sat_neg ? SAT_LO : wide[DW-1:0]);
  assign ovf_o   = ovf_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  ovf_reg <= 1'b0;
    else if (in_fire && (sat_pos || sat_neg)) ovf_reg <= 1'b1;
  end
`else
  assign sum   = base + data_i;
  assign ovf_o = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (in_fire) begin
      if (last_word) begin
        cnt_reg <= '0;
      end else begin
        acc_reg <= sum;
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  merge_fifo #(
    .DW         (DW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (sum),
    .pop       (pop),
    .pop_data  (data_o),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );
endmodule

// File: tb/tb_merge_accumulator.sv
// Directed bench for merge_accumulator (MERGE_NUM=3 main instance, MERGE_NUM=1 second instance).
// Expected saturation results follow MERGE_ACC_SAT_EN.
module tb_merge_accumulator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [15:0] data_o;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [4:0]  acc_cnt_o;
  logic        ovf_o;

  logic [15:0] data_i1 = '0;
  logic        valid_i1 = 1'b0;
  logic        ready_o1;
  logic [15:0] data_o1;
  logic        valid_o1;
  logic [4:0]  acc_cnt_o1;
  logic        ovf_o1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  merge_accumulator #(.DW(16), .MERGE_NUM(3), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .acc_cnt_o(acc_cnt_o), .ovf_o(ovf_o)
  );

  merge_accumulator #(.DW(16), .MERGE_NUM(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .data_i(data_i1), .valid_i(valid_i1), .ready_o(ready_o1),
    .data_o(data_o1), .valid_o(valid_o1), .ready_i(1'b1),
    .acc_cnt_o(acc_cnt_o1), .ovf_o(ovf_o1)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // One accepted word: verifies the group position before the edge
  task automatic send(input int v, input int exp_cnt);
    valid_i = 1'b1;
    data_i  = 16'(v);
    #1;
    check("acc_cnt_before_accept", int'(acc_cnt_o), exp_cnt);
    check("ready_before_accept", int'(ready_o), 1);
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    int sat_exp;
    int ovf_exp;
`ifdef MERGE_ACC_SAT_EN
    sat_exp = 32767;
    ovf_exp = 1;
`else
    sat_exp = -5526;
    ovf_exp = 0;
`endif

    tick(); tick();
    check("reset_valid", int'(valid_o), 0);
    check("reset_data", int'(data_o), 0);
    check("reset_cnt", int'(acc_cnt_o), 0);
    rst = 1'b0;
    #1;
    check("reset_ready", int'(ready_o), 1);
    check("reset_ovf", int'(ovf_o), 0);
    tick();

    // Two groups back to back
    send(5, 0); send(7, 1); send(-2, 2);
    check("grp1_valid", int'(valid_o), 1);
    check("grp1_data", int'($signed(data_o)), 10);
    check("grp1_cnt", int'(acc_cnt_o), 0);
    send(1, 0); send(1, 1); send(1, 2);
    check("grp2_data", int'($signed(data_o)), 3);
    check("grp2_cnt", int'(acc_cnt_o), 0);
    tick();
    check("drained_valid", int'(valid_o), 0);

    // Fill the buffer with ready_i low until the closing word stalls
    ready_i = 1'b0;
    for (int i = 0; i < 15; i++) begin
      valid_i = 1'b1;
      data_i  = 16'd1;
      #1;
      if (i == 14) begin
        check("stall_ready", int'(ready_o), 0);
        check("stall_cnt", int'(acc_cnt_o), 2);
      end else if (i >= 12) begin
        check("fill_ready", int'(ready_o), 1);
      end
      @(posedge clk); #1;
    end
    check("stall_held_cnt", int'(acc_cnt_o), 2);
    check("stall_head", int'($signed(data_o)), 3);
    check("stall_valid", int'(valid_o), 1);
    ready_i = 1'b1;
    #1;
    check("push_pop_full_ready", int'(ready_o), 1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    check("push_pop_full_cnt", int'(acc_cnt_o), 0);
    for (int k = 0; k < 4; k++) begin
      check("drain_valid", int'(valid_o), 1);
      check("drain_data", int'($signed(data_o)), 3);
      tick();
    end
    check("drain_empty", int'(valid_o), 0);

    // Overflow behaviour
    send(30000, 0); send(30000, 1); send(10, 2);
    check("ovf_data", int'($signed(data_o)), sat_exp);
    check("ovf_flag", int'(ovf_o), ovf_exp);
    tick();
    check("ovf_sticky", int'(ovf_o), ovf_exp);

    // Reset mid-group with results buffered
    ready_i = 1'b0;
    for (int i = 0; i < 6; i++) send(1, i % 3);
    send(1, 0); send(1, 1);
    check("pre_rst_valid", int'(valid_o), 1);
    rst = 1'b1;
    #2;
    check("rst_async_valid", int'(valid_o), 0);
    check("rst_async_cnt", int'(acc_cnt_o), 0);
    check("rst_async_data", int'(data_o), 0);
    check("rst_async_ovf", int'(ovf_o), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ready_i = 1'b1;
    tick();
    check("post_rst_valid", int'(valid_o), 0);
    send(4, 0); send(4, 1); send(4, 2);
    check("post_rst_data", int'($signed(data_o)), 12);
    check("post_rst_valid_one", int'(valid_o), 1);
    tick();
    check("post_rst_sole", int'(valid_o), 0);

    // MERGE_NUM = 1 passes words straight through
    valid_i1 = 1'b1;
    data_i1  = 16'd9;
    #1;
    check("m1_ready", int'(ready_o1), 1);
    @(posedge clk); #1;
    check("m1_valid_a", int'(valid_o1), 1);
    check("m1_data_a", int'($signed(data_o1)), 9);
    data_i1 = 16'(-9);
    @(posedge clk); #1;
    valid_i1 = 1'b0;
    check("m1_valid_b", int'(valid_o1), 1);
    check("m1_data_b", int'($signed(data_o1)), -9);
    check("m1_cnt", int'(acc_cnt_o1), 0);
    tick();
    check("m1_empty", int'(valid_o1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
